// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse cipher: FSM encoding, round constants,
// GF(2^8) helpers and the whole-state inverse ShiftRows / MixColumns transforms.
package aes_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_KEXP  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte 4c+r sits at [127-8*(4c+r) -: 8]; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, combinational lookup. Entry 0 is the most significant byte of the table.
module aes_inv_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [2047:0] TABLE = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };

    assign o_out = TABLE[{~i_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational lookup. Entry 0 is the most significant byte of the table.
module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [2047:0] TABLE = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry i lives at bit offset 8*(255-i), and 255-i is ~i for a byte.
    assign o_out = TABLE[{~i_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher128.sv
// Iterative AES-128 decryptor: expands the key forward to rk10, then runs one inverse round
// per clock while walking the key schedule backwards.
module aes_inv_cipher128 #(
    parameter int unsigned NR = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_data,
    input  logic [127:0] i_key,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_data
);

    import aes_pkg::*;

    if (NR != 10) begin : g_bad_nr
        $error("aes_inv_cipher128: only NR = 10 is supported");
    end

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [127:0] r_st;
    logic [127:0] r_rk;
    logic [127:0] r_out_data;
    logic [3:0]   r_cnt;

    logic [31:0]  w_a0, w_a1, w_a2, w_a3;
    logic [31:0]  w_b0, w_b1, w_b2, w_b3;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [31:0]  w_ks_in, w_ks_rot, w_ks_sub, w_ks_t;
    logic [3:0]   w_rcon_idx;
    logic [127:0] w_rk_fwd, w_rk_inv;
    logic [127:0] w_isr, w_isb, w_ark, w_round;
    logic         w_in_fire;

    assign w_in_fire = i_in_valid && (r_state == S_IDLE);

    // Key path: one shared SubWord serves the forward step in KEXP and the inverse step in ROUND.
    assign {w_a0, w_a1, w_a2, w_a3} = r_rk;
    assign w_b3       = w_a3 ^ w_a2;
    assign w_b2       = w_a2 ^ w_a1;
    assign w_b1       = w_a1 ^ w_a0;
    assign w_ks_in    = (r_state == S_ROUND) ? w_b3 : w_a3;
    assign w_ks_rot   = {w_ks_in[23:0], w_ks_in[31:24]};
    assign w_rcon_idx = (r_state == S_ROUND) ? (r_cnt + 4'd1) : r_cnt;
    assign w_ks_t     = w_ks_sub ^ {rcon(w_rcon_idx), 24'h000000};

    for (genvar k = 0; k < 4; k++) begin : g_ks_sbox
        aes_sbox u_sbox (
            .i_in  (w_ks_rot[8 * k +: 8]),
            .o_out (w_ks_sub[8 * k +: 8])
        );
    end

    assign w_n0     = w_a0 ^ w_ks_t;
    assign w_n1     = w_a1 ^ w_n0;
    assign w_n2     = w_a2 ^ w_n1;
    assign w_n3     = w_a3 ^ w_n2;
    assign w_rk_fwd = {w_n0, w_n1, w_n2, w_n3};
    assign w_b0     = w_a0 ^ w_ks_t;
    assign w_rk_inv = {w_b0, w_b1, w_b2, w_b3};

    assign w_isr = inv_shift_rows(r_st);

    for (genvar k = 0; k < 16; k++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (
            .i_in  (w_isr[8 * k +: 8]),
            .o_out (w_isb[8 * k +: 8])
        );
    end

    assign w_ark   = w_isb ^ w_rk_inv;
    assign w_round = (r_cnt == 4'd0) ? w_ark : inv_mix_columns(w_ark);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_in_valid) w_state_nxt = S_KEXP;
            S_KEXP:  if (r_cnt == 4'(NR)) w_state_nxt = S_ROUND;
            S_ROUND: if (r_cnt == 4'd0) w_state_nxt = S_DONE;
            S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == S_IDLE);
        o_out_valid = (r_state == S_DONE);
    end

    assign o_out_data = r_out_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st       <= '0;
            r_rk       <= '0;
            r_out_data <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_st  <= i_in_data;
                        r_rk  <= i_key;
                        r_cnt <= 4'd1;
                    end
                end
                S_KEXP: begin
                    r_rk <= w_rk_fwd;
                    if (r_cnt == 4'(NR)) begin
                        r_st  <= r_st ^ w_rk_fwd;
                        r_cnt <= 4'(NR - 1);
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ROUND: begin
                    r_st <= w_round;
                    r_rk <= w_rk_inv;
                    if (r_cnt == 4'd0) begin
                        r_out_data <= w_round;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher128.sv
// Scoreboard bench: a forward AES-128 model encrypts random plaintexts, the DUT must recover them.
module tb_aes_inv_cipher128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_data = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;

    aes_inv_cipher128 dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_key       (key),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    logic         prev_valid = 1'b0;
    logic [7:0]   sbox_m[256];
    logic [31:0]  kw[44];

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) kw[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = kw[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t ^= {rc, 24'h000000};
                rc = gm(rc, 8'h02);
            end
            kw[i] = kw[i - 4] ^ t;
        end
    endtask

    task automatic encrypt(input logic [127:0] pt, input logic [127:0] k, output logic [127:0] ct);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] a0, a1, a2, a3;
        expand(k);
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
                s = t;
                if (rnd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                        s[4 * c]     = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
                        s[4 * c + 1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
                        s[4 * c + 2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
                        s[4 * c + 3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4 * c + r] ^= kw[4 * rnd + c][31 - 8 * r -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
    endtask

    // Returns just after the accepting edge; acc is the cycle count at that edge.
    task automatic send(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] exp,
                        output int acc);
        in_data  = ct;
        key      = k;
        in_valid = 1'b1;
        acc      = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc + 1;
                exp_q.push_back(exp);
                acc_q.push_back(acc);
                break;
            end
        end
        if (acc < 0) timeout("send");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            timeout("drain");
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 128'(out_valid), 128'(0));
            end else begin
                if (!prev_valid) check("latency", 128'(cyc - acc_q[0]), 128'(20));
                check("out_data", out_data, exp_q[0]);
                check("in_ready_busy", 128'(in_ready), 128'(0));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
        end
        prev_valid = rst_n && out_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           a1, a2;
        logic [127:0] pt, k, ct;
        build_sbox();

        #12;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector 1 with the round key after forward expansion.
        expand(K1);
        send(C1, K1, P1, a1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rk10", dut.r_rk, {kw[40], kw[41], kw[42], kw[43]});
        drain();

        send(C2, K2, P2, a1);
        drain();

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(C1, K1, P1, a1);
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after", 128'(in_ready), 128'(1));
        check("bp_out_valid_after", 128'(out_valid), 128'(0));
        check("bp_data_kept", out_data, P1);
        check("bp_queue_empty", 128'(exp_q.size()), 128'(0));

        // in_valid pulses while busy must be ignored.
        send(C1, K1, P1, a1);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = {4{$urandom}}; key = {4{$urandom}};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = {4{$urandom}}; key = {4{$urandom}};
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a job.
        send(C1, K1, P1, a1);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(C2, K2, P2, a1);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        send(C1, K1, P1, a1);
        send(C2, K2, P2, a2);
        check("b2b_gap", 128'(a2 - a1), 128'(22));
        drain();

        for (int n = 0; n < 8; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            encrypt(pt, k, ct);
            send(ct, k, pt, a1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
